// File: rtl/aes_round_engine.sv
// AES-128 encrypt round engine: one round per cycle, valid/ready in and out.
// Optional completed-block counter enabled by defining AES_ENGINE_PERF_EN.
package aes_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_ADD_KEY,
    S_PROCESS_ROUNDS,
    S_FINAL_ROUND,
    S_DONE
  } aes_core_state_t;
endpackage

module aes_round_engine
  import aes_pkg::*;
#(
  parameter int NR         = 10,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [127:0]          pt_i,
  input  logic [127:0]          key_i,
  input  logic [127:0]          round_key_i,
  output aes_core_state_t       state_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
`ifdef AES_ENGINE_PERF_EN
  output logic [PERF_CNT_W-1:0] blk_cnt_o,
`endif
  output logic [127:0]          ct_o
);

  if (NR != 10) begin : g_nr_bad
    $error("aes_round_engine: NR must be 10");
  end
  if (PERF_CNT_W < 1) begin : g_w_bad
    $error("aes_round_engine: PERF_CNT_W must be >= 1");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // key_i is consumed by key_schedule; the engine only sees round keys.
  logic unused_key;
  assign unused_key = ^key_i;

  aes_core_state_t state, nxt;
  logic [127:0] data;
  logic [3:0]   rnd_cnt;

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] sr_w;
  logic [127:0] mc_w;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign state_o     = state;
  assign in_ready_o  = (state == S_IDLE) & rst_n;
  assign out_valid_o = (state == S_DONE);
  assign ct_o        = data;

  // byte i lives at row i%4, column i/4
  always_comb begin
    sr_w = '0;
    mc_w = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(data[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[r+4*c] = sb[r+4*((c+r)%4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1]
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2])
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2])
                ^ xt(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                ^ sr[4*c+2] ^ xt(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      sr_w[127-8*i -: 8] = sr[i];
      mc_w[127-8*i -: 8] = mc[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:           if (in_valid_i) nxt = S_INIT_ADD_KEY;
      S_INIT_ADD_KEY:   nxt = S_PROCESS_ROUNDS;
      S_PROCESS_ROUNDS: if (rnd_cnt == 4'(NR - 1)) nxt = S_FINAL_ROUND;
      S_FINAL_ROUND:    nxt = S_DONE;
      S_DONE:           if (out_ready_i) nxt = S_IDLE;
      default:          nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      rnd_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid_i) data <= pt_i;
        S_INIT_ADD_KEY: begin
          data    <= data ^ round_key_i;
          rnd_cnt <= 4'd1;
        end
        S_PROCESS_ROUNDS: begin
          data    <= mc_w ^ round_key_i;
          rnd_cnt <= rnd_cnt + 4'd1;
        end
        S_FINAL_ROUND: data <= sr_w ^ round_key_i;
        default: ;
      endcase
    end
  end

`ifdef AES_ENGINE_PERF_EN
  logic [PERF_CNT_W-1:0] blk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blk_cnt <= '0;
    else if (out_valid_o && out_ready_i)
      blk_cnt <= blk_cnt + PERF_CNT_W'(1);
  end

  assign blk_cnt_o = blk_cnt;
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
// Scoreboard bench for aes_round_engine with a GF(2^8)-arithmetic AES model.
// Block counter checks run when AES_ENGINE_PERF_EN is defined.
module tb_aes_round_engine;
  import aes_pkg::*;

  localparam int W = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [127:0]    pt_i = '0;
  logic [127:0]    key_i = '0;
  logic [127:0]    round_key_i;
  aes_core_state_t state_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [127:0]    ct_o;
`ifdef AES_ENGINE_PERF_EN
  logic [W-1:0]    blk_cnt_o;
`endif

  logic rdy_man = 1'b1;
  logic rand_rdy = 1'b0;
  logic rnd_bit = 1'b0;
  assign out_ready_i = rand_rdy ? rnd_bit : rdy_man;

  aes_round_engine #(.NR(10), .PERF_CNT_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .pt_i        (pt_i),
    .key_i       (key_i),
    .round_key_i (round_key_i),
    .state_o     (state_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
`ifdef AES_ENGINE_PERF_EN
    .blk_cnt_o   (blk_cnt_o),
`endif
    .ct_o        (ct_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbx [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbx[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
             ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic void expand(input logic [127:0] key,
                                 output logic [127:0] rk [0:10]);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]], sbx[t[31:24]]};
        t = t ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt,
                                           input logic [127:0] key);
    logic [127:0] rk [0:10];
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [127:0] res = '0;
    expand(key, rk);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk[0][127-8*(4*c+r) -: 8];
    for (int n = 1; n <= 10; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbx[s[r][(c+r)%4]];
      if (n < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                    ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
      end else begin
        s = t;
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ rk[n][127-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- key_schedule stand-in ----------------
  logic [127:0] cur_rks [0:10];
  logic [3:0]   idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idx <= 4'd0;
    else if (state_o == S_IDLE)
      idx <= 4'd0;
    else if (state_o == S_INIT_ADD_KEY || state_o == S_PROCESS_ROUNDS)
      idx <= idx + 4'd1;
  end

  assign round_key_i = cur_rks[(idx > 4'd10) ? 4'd10 : idx];

  // ---------------- scoreboard monitor ----------------
  logic [127:0] exp_q [$];
  int exp_blk = 0;
  bit pend = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
`ifdef AES_ENGINE_PERF_EN
      if (pend) check("blk_cnt", 128'(blk_cnt_o), 128'(W'(exp_blk)));
`endif
      pend = 1'b0;
      if (rst_n && out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ct: got %h expected no output", ct_o);
        end else begin
          check("ct", ct_o, exp_q.pop_front());
        end
        exp_blk++;
        pend = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] exp);
    int n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      return;
    end
    in_valid_i = 1'b1;
    pt_i = pt;
    key_i = key;
    expand(key, cur_rks);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    pt_i = rnd128();
    key_i = rnd128();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || state_o != S_IDLE) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 128'(n < 300), 128'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_blk = 0;
    pend = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit flag;
    logic [127:0] hold;
    logic [127:0] p, k;

    build_sbox();
    expand(K1, cur_rks);

    #12;
    check("rst_state", 128'(state_o), 128'(S_IDLE));
    check("rst_out_valid", 128'(out_valid_o), 128'(0));
    check("rst_in_ready", 128'(in_ready_o), 128'(0));
    check("rst_ct", ct_o, 128'(0));
`ifdef AES_ENGINE_PERF_EN
    check("rst_blk_cnt", 128'(blk_cnt_o), 128'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // T1 with latency and busy-ready observation
    rdy_man = 1'b1;
    send(P1, K1, C1);
    n = 0;
    flag = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (in_ready_o) flag = 1'b0;
    end while (!out_valid_o && n < 40);
    check("t1_latency", 128'(n), 128'(12));
    check("t1_busy_no_ready", 128'(flag), 128'(1));
    @(posedge clk);
    #1;
    check("t1_idle_after", 128'(state_o), 128'(S_IDLE));

    // T2
    send(P2, K2, C2);
    drain();

    // T3 backpressure
    rdy_man = 1'b0;
    send(P1, K1, C1);
    n = 0;
    while (!out_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    hold = ct_o;
    flag = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ct_o !== hold || in_ready_o || !out_valid_o) flag = 1'b0;
    end
    check("t3_hold_stable", 128'(flag), 128'(1));
    check("t3_held_ct", ct_o, C1);
    @(posedge clk);
    #1;
    rdy_man = 1'b1;
    @(posedge clk);
    #1;
    rdy_man = 1'b0;
    check("t3_idle_next", 128'(state_o), 128'(S_IDLE));
    check("t3_valid_drop", 128'(out_valid_o), 128'(0));
    rdy_man = 1'b1;

    // T4 in_valid while busy
    send(P1, K1, C1);
    repeat (5) @(negedge clk);
    in_valid_i = 1'b1;
    pt_i = rnd128();
    key_i = rnd128();
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    drain();
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid_o) flag = 1'b1;
    end
    check("t4_no_second_block", 128'(flag), 128'(0));

    // T5 reset mid-round
    send(P2, K2, C2);
    repeat (6) @(negedge clk);
    do_reset();
    check("t5_state", 128'(state_o), 128'(S_IDLE));
    check("t5_out_valid", 128'(out_valid_o), 128'(0));
    check("t5_in_ready", 128'(in_ready_o), 128'(0));
    check("t5_ct_clear", ct_o, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send(P2, K2, C2);
    drain();

    // random blocks with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p = rnd128();
      k = rnd128();
      send(p, k, encrypt(p, k));
    end
    drain();
    rand_rdy = 1'b0;
    check("model_fips_t1", encrypt(P1, K1), C1);

    // T6 back-to-back blocks after reset; counter wraps at 2 bits
    do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_man = 1'b1;
    for (int i = 0; i < 5; i++) send(P1, K1, C1);
    drain();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
